// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array result-drain path.
package systolic_pkg;

    localparam int unsigned PE_NUMBER_DEF = 64;
    localparam int unsigned WORD_SIZE_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        STREAM,
        CLEAR
    } drain_state_t;

    typedef logic [WORD_SIZE_DEF-1:0] word_t;

endpackage

// File: rtl/systolic_drain_buffer.sv
// PE_NUMBER x WORD_SIZE register file holding one drained result row:
// one synchronous write port, one combinational read port.
module drain_buffer #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/systolic_drain.sv
// Drains the PE array's serial result chain into a buffer and replays it as a
// valid/ready stream. Define DRAIN_REVERSE_EN to emit words from PE_NUMBER-1 down to 0.
module systolic_drain
    import systolic_pkg::*;
#(
    parameter int unsigned PE_NUMBER    = PE_NUMBER_DEF,
    parameter int unsigned WORD_SIZE    = WORD_SIZE_DEF,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         arr_read,
    input  logic [WORD_SIZE-1:0]         arr_d_i,
    output logic                         arr_clr,
    output logic [WORD_SIZE-1:0]         m_data,
    output logic [$clog2(PE_NUMBER)-1:0] m_index,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         m_last
);

    localparam int unsigned CW = $clog2(PE_NUMBER + 1);
    localparam int unsigned IW = $clog2(PE_NUMBER);
    localparam logic [CW-1:0] LAST = CW'(PE_NUMBER - 1);

    drain_state_t state;
    logic [CW-1:0] rcnt;
    logic [CW-1:0] wcnt;
    logic [CW-1:0] rd;
    logic [READ_LATENCY-1:0] lat_pipe;
    logic sample;
    logic [IW-1:0] rd_idx;
    logic [WORD_SIZE-1:0] rdata;

    // Each arr_read cycle marks the array output valid READ_LATENCY cycles later.
    assign sample = lat_pipe[READ_LATENCY-1];

`ifdef DRAIN_REVERSE_EN
    assign rd_idx = IW'(LAST - rd);
`else
    assign rd_idx = rd[IW-1:0];
`endif

    drain_buffer #(
        .DEPTH (PE_NUMBER),
        .WIDTH (WORD_SIZE)
    ) u_buf (
        .clk   (clk),
        .we    (sample && (state == DRAIN)),
        .waddr (wcnt[IW-1:0]),
        .wdata (arr_d_i),
        .raddr (rd_idx),
        .rdata (rdata)
    );

    assign busy    = (state != IDLE);
    assign m_data  = m_valid ? rdata : '0;
    assign m_index = m_valid ? rd_idx : '0;
    assign m_last  = m_valid && (rd == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_pipe <= '0;
        end else begin
            lat_pipe <= (lat_pipe << 1) | READ_LATENCY'(arr_read);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            arr_read <= 1'b0;
            arr_clr  <= 1'b0;
            done     <= 1'b0;
            m_valid  <= 1'b0;
            rcnt     <= '0;
            wcnt     <= '0;
            rd       <= '0;
        end else begin
            arr_clr <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= DRAIN;
                        arr_read <= 1'b1;
                        rcnt     <= '0;
                        wcnt     <= '0;
                    end
                end
                DRAIN: begin
                    if (arr_read) begin
                        rcnt <= rcnt + 1'b1;
                        if (rcnt == LAST) begin
                            arr_read <= 1'b0;
                        end
                    end
                    if (sample) begin
                        wcnt <= wcnt + 1'b1;
                        if (wcnt == LAST) begin
                            state   <= STREAM;
                            m_valid <= 1'b1;
                            rd      <= '0;
                        end
                    end
                end
                STREAM: begin
                    if (m_ready) begin
                        if (rd == LAST) begin
                            state   <= CLEAR;
                            m_valid <= 1'b0;
                            arr_clr <= 1'b1;
                            done    <= 1'b1;
                        end else begin
                            rd <= rd + 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_drain.sv
// Self-checking bench for systolic_drain with a behavioural serial-shift array model.
module tb_systolic_drain;
    import systolic_pkg::*;

    localparam int unsigned PE = 4;
    localparam int unsigned WS = 16;
    localparam int unsigned RL = 1;
`ifdef DRAIN_REVERSE_EN
    localparam bit REV = 1'b1;
`else
    localparam bit REV = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, start, busy, done, arr_read, arr_clr, m_valid, m_ready, m_last;
    logic [WS-1:0] arr_d_i = '0;
    logic [WS-1:0] m_data;
    logic [1:0]    m_index;

    int checks = 0;
    int failures = 0;

    systolic_drain #(
        .PE_NUMBER    (PE),
        .WORD_SIZE    (WS),
        .READ_LATENCY (RL)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .arr_read (arr_read),
        .arr_d_i  (arr_d_i),
        .arr_clr  (arr_clr),
        .m_data   (m_data),
        .m_index  (m_index),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_last   (m_last)
    );

    always #5 clk = ~clk;

    // Array model: contents of the PE chain, shifted out PE0 first.
    logic [WS-1:0] arr_words [PE];
    logic pend = 1'b0;
    logic was  = 1'b0;
    int   ptr  = 0;

    // Monitor state (written only by the monitor processes).
    int cyc = 0;
    int n_read = 0, n_done = 0, n_clr = 0;
    int rise_read = -1, rise_valid = -1, done_cyc = -1;
    logic prev_read = 1'b0, prev_valid = 1'b0;
    logic [WS-1:0] got_d [$];
    logic [1:0]    got_i [$];
    logic          got_l [$];

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (pend) begin
            if (!was) ptr = 0;
            if (ptr < PE) arr_d_i = arr_words[ptr];
            ptr++;
        end
        was = pend;
    end

    always @(negedge clk) begin
        pend = (arr_read === 1'b1);
        if (arr_read === 1'b1) begin
            if (!prev_read) rise_read = cyc;
            n_read++;
        end
        if (m_valid === 1'b1 && !prev_valid) rise_valid = cyc;
        prev_read  = (arr_read === 1'b1);
        prev_valid = (m_valid === 1'b1);
        if (done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
        end
        if (arr_clr === 1'b1) n_clr++;
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            got_d.push_back(m_data);
            got_i.push_back(m_index);
            got_l.push_back(m_last);
        end
    end

    // Reference ordering derived from the stream rules.
    function automatic logic [WS-1:0] exp_word(int k);
        return arr_words[REV ? PE - 1 - k : k];
    endfunction

    function automatic logic [1:0] exp_idx(int k);
        return 2'(REV ? PE - 1 - k : k);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_words(input bit directed);
        for (int k = 0; k < PE; k++)
            arr_words[k] = directed ? WS'((k + 1) * 10) : WS'($urandom);
    endtask

    task automatic wait_done(input int budget, input bit rnd, output bit ok);
        int b;
        b = n_done;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (rnd) m_ready = 1'($urandom_range(0, 1));
            tick;
            if (n_done != b) begin
                ok = 1'b1;
                break;
            end
        end
        m_ready = 1'b1;
    endtask

    task automatic test_reset;
        int b_read;
        reset = 1'b1;
        start = 1'b1;
        m_ready = 1'b0;
        b_read = n_read;
        repeat (3) begin
            tick;
            checks++;
            if ({busy, done, arr_read, arr_clr, m_valid, m_last} !== 6'b0) begin
                failures++;
                $display("FAIL reset_ctrl got=%b exp=000000", {busy, done, arr_read, arr_clr, m_valid, m_last});
            end
            checks++;
            if (m_data !== '0 || m_index !== '0) begin
                failures++;
                $display("FAIL reset_data got=%0h/%0d exp=0/0", m_data, m_index);
            end
        end
        checks++;
        if (n_read != b_read) begin
            failures++;
            $display("FAIL reset_no_read got=%0d exp=%0d", n_read - b_read, 0);
        end
        reset = 1'b0;
        start = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        int s, b_read, b_clr, b_got;
        bit ok;
        load_words(1'b1);
        m_ready = 1'b1;
        b_read = n_read; b_clr = n_clr; b_got = got_d.size();
        start = 1'b1;
        s = cyc;
        tick;
        start = 1'b0;
        wait_done(40, 1'b0, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL basic_timeout got=0 exp=1"); end
        checks++;
        if (rise_read != s + 1 || n_read - b_read != PE) begin
            failures++;
            $display("FAIL basic_read got=start+%0d,n=%0d exp=start+1,n=%0d", rise_read - s, n_read - b_read, PE);
        end
        checks++;
        if (rise_valid != s + 1 + PE + RL) begin
            failures++;
            $display("FAIL basic_first_valid got=start+%0d exp=start+%0d", rise_valid - s, 1 + PE + RL);
        end
        checks++;
        if (done_cyc - s != 1 + PE + RL + PE) begin
            failures++;
            $display("FAIL basic_done_latency got=%0d exp=%0d", done_cyc - s, 1 + PE + RL + PE);
        end
        checks++;
        if (n_clr - b_clr != 1) begin failures++; $display("FAIL basic_clr got=%0d exp=1", n_clr - b_clr); end
        checks++;
        if (got_d.size() - b_got != PE) begin
            failures++;
            $display("FAIL basic_count got=%0d exp=%0d", got_d.size() - b_got, PE);
        end else begin
            for (int k = 0; k < PE; k++) begin
                checks++;
                if (got_d[b_got+k] !== exp_word(k) || got_i[b_got+k] !== exp_idx(k) || got_l[b_got+k] !== (k == PE - 1)) begin
                    failures++;
                    $display("FAIL basic_word%0d got=%0d/%0d/%b exp=%0d/%0d/%b", k, got_d[b_got+k], got_i[b_got+k],
                             got_l[b_got+k], exp_word(k), exp_idx(k), k == PE - 1);
                end
            end
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || m_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_idle got=%b%b%b exp=000", busy, done, m_valid);
        end
    endtask

    task automatic test_backpressure;
        int s, b_done, b_got, stall;
        bit ok;
        load_words(1'b0);
        m_ready = 1'b1;
        b_done = n_done; b_got = got_d.size();
        start = 1'b1;
        s = cyc;
        tick;
        start = 1'b0;
        stall = 0;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (m_valid === 1'b1 && got_d.size() - b_got == 1 && stall < 3) begin
                m_ready = 1'b0;
                stall++;
                checks++;
                if (m_data !== exp_word(1) || m_index !== exp_idx(1) || m_last !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_hold%0d got=%0d/%0d/%b exp=%0d/%0d/0", stall, m_data, m_index, m_last,
                             exp_word(1), exp_idx(1));
                end
            end else begin
                m_ready = 1'b1;
            end
            if (n_done != b_done) begin
                ok = 1'b1;
                break;
            end
            tick;
        end
        m_ready = 1'b1;
        checks++;
        if (!ok || stall != 3) begin failures++; $display("FAIL bp_progress got=%0d/%0d exp=1/3", ok, stall); end
        checks++;
        if (done_cyc - s != 1 + PE + RL + PE + 3) begin
            failures++;
            $display("FAIL bp_latency got=%0d exp=%0d", done_cyc - s, 1 + PE + RL + PE + 3);
        end
        checks++;
        if (got_d.size() - b_got != PE) begin
            failures++;
            $display("FAIL bp_count got=%0d exp=%0d", got_d.size() - b_got, PE);
        end else begin
            for (int k = 0; k < PE; k++) begin
                checks++;
                if (got_d[b_got+k] !== exp_word(k) || got_i[b_got+k] !== exp_idx(k)) begin
                    failures++;
                    $display("FAIL bp_word%0d got=%0d/%0d exp=%0d/%0d", k, got_d[b_got+k], got_i[b_got+k], exp_word(k), exp_idx(k));
                end
            end
        end
    endtask

    task automatic test_start_ignored;
        int b_read, b_done, b_clr, b_got;
        bit ok;
        load_words(1'b0);
        m_ready = 1'b1;
        b_read = n_read; b_done = n_done; b_clr = n_clr; b_got = got_d.size();
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 20 && m_valid !== 1'b1; i++) tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        wait_done(40, 1'b0, ok);
        repeat (12) tick;
        checks++;
        if (!ok || n_done - b_done != 1 || n_clr - b_clr != 1) begin
            failures++;
            $display("FAIL ign_done got=%0d/%0d exp=1/1", n_done - b_done, n_clr - b_clr);
        end
        checks++;
        if (n_read - b_read != PE || busy !== 1'b0) begin
            failures++;
            $display("FAIL ign_single got=%0d/%b exp=%0d/0", n_read - b_read, busy, PE);
        end
        checks++;
        if (got_d.size() - b_got != PE) begin
            failures++;
            $display("FAIL ign_count got=%0d exp=%0d", got_d.size() - b_got, PE);
        end else begin
            for (int k = 0; k < PE; k++) begin
                checks++;
                if (got_d[b_got+k] !== exp_word(k)) begin
                    failures++;
                    $display("FAIL ign_word%0d got=%0d exp=%0d", k, got_d[b_got+k], exp_word(k));
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int b_done, b_clr, b_got;
        bit ok;
        load_words(1'b0);
        m_ready = 1'b1;
        b_done = n_done; b_clr = n_clr; b_got = got_d.size();
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 40 && got_d.size() - b_got < 2; i++) tick;
        reset = 1'b1;
        m_ready = 1'b0;
        tick;
        reset = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || arr_read !== 1'b0 || m_last !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_idle got=%b%b%b%b exp=0000", m_valid, busy, arr_read, m_last);
        end
        repeat (5) tick;
        checks++;
        if (n_done != b_done || n_clr != b_clr || got_d.size() - b_got != 2) begin
            failures++;
            $display("FAIL rstmid_abort got=%0d/%0d/%0d exp=0/0/2", n_done - b_done, n_clr - b_clr, got_d.size() - b_got);
        end
        load_words(1'b0);
        m_ready = 1'b1;
        b_got = got_d.size();
        start = 1'b1;
        tick;
        start = 1'b0;
        wait_done(40, 1'b0, ok);
        checks++;
        if (!ok || got_d.size() - b_got != PE) begin
            failures++;
            $display("FAIL rstmid_redrain got=%0d/%0d exp=1/%0d", ok, got_d.size() - b_got, PE);
        end else begin
            for (int k = 0; k < PE; k++) begin
                checks++;
                if (got_d[b_got+k] !== exp_word(k) || got_i[b_got+k] !== exp_idx(k)) begin
                    failures++;
                    $display("FAIL rstmid_word%0d got=%0d/%0d exp=%0d/%0d", k, got_d[b_got+k], got_i[b_got+k], exp_word(k), exp_idx(k));
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        int b_done, b_clr, b_got;
        bit ok;
        for (int r = 0; r < 3; r++) begin
            load_words(1'b0);
            b_done = n_done; b_clr = n_clr; b_got = got_d.size();
            start = 1'b1;
            tick;
            start = 1'b0;
            wait_done(200, 1'b1, ok);
            checks++;
            if (!ok || n_done - b_done != 1 || n_clr - b_clr != 1 || got_d.size() - b_got != PE) begin
                failures++;
                $display("FAIL b2b%0d_summary got=%0d/%0d/%0d exp=1/1/%0d", r, n_done - b_done, n_clr - b_clr,
                         got_d.size() - b_got, PE);
            end else begin
                for (int k = 0; k < PE; k++) begin
                    checks++;
                    if (got_d[b_got+k] !== exp_word(k) || got_i[b_got+k] !== exp_idx(k) || got_l[b_got+k] !== (k == PE - 1)) begin
                        failures++;
                        $display("FAIL b2b%0d_word%0d got=%0d/%0d/%b exp=%0d/%0d/%b", r, k, got_d[b_got+k], got_i[b_got+k],
                                 got_l[b_got+k], exp_word(k), exp_idx(k), k == PE - 1);
                    end
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        m_ready = 1'b0;
        test_reset;
        test_basic;
        test_backpressure;
        test_start_ignored;
        test_reset_mid;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
